// File: rtl/ervp_cache_backend_arb_pkg.sv
// Shared definitions for the cache backend arbiter: arbiter state encoding and
// width helpers for port indices and order-FIFO pointers.
package ervp_cache_backend_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // ceil(log2(n)), never below 1 so a 2-entry space still gets a 1-bit index
  function automatic int log2ru_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return log2ru_min1(depth);
  endfunction

endpackage

// File: rtl/ervp_cache_backend_arb_order_fifo.sv
// Order FIFO remembering which port owns each outstanding response, oldest at head.
module ervp_cache_order_fifo
  import ervp_cache_backend_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read while count is non-zero
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/ervp_cache_backend_arb.sv
// Merges NUM_INTERFACE request ports onto one memory port (round-robin, packet-locked)
// and routes memory responses back to their requesters in issue order.
module ervp_cache_backend_arb
  import ervp_cache_backend_arb_pkg::*;
#(
  parameter int NUM_INTERFACE = 2,
  parameter int BW_QDATA      = 64,
  parameter int BW_YDATA      = 32,
  parameter int ORDER_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              enable,
  output logic                              busy,
  input  logic [NUM_INTERFACE-1:0]          rq_valid_list,
  input  logic [NUM_INTERFACE-1:0]          rq_last_list,
  input  logic [NUM_INTERFACE-1:0]          rq_afy_list,
  input  logic [BW_QDATA*NUM_INTERFACE-1:0] rq_data_list,
  output logic [NUM_INTERFACE-1:0]          rq_ready_list,
  output logic [NUM_INTERFACE-1:0]          ry_valid_list,
  output logic [NUM_INTERFACE-1:0]          ry_last_list,
  output logic [BW_YDATA*NUM_INTERFACE-1:0] ry_data_list,
  input  logic [NUM_INTERFACE-1:0]          ry_ready_list,
  output logic                              sq_valid,
  output logic                              sq_last,
  output logic                              sq_afy,
  output logic [BW_QDATA-1:0]               sq_data,
  input  logic                              sq_ready,
  input  logic                              sy_valid,
  input  logic                              sy_last,
  input  logic [BW_YDATA-1:0]               sy_data,
  output logic                              sy_ready,
  output logic                              orphan_error
);

  localparam int IDX_W = log2ru_min1(NUM_INTERFACE);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   held_q, held_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               orphan_q, orphan_d;

  logic               flush;
  logic [NUM_INTERFACE-1:0] cand;
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   k;
  logic               sq_hs;
  logic               sy_hs;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [IDX_W-1:0]   fifo_head;

  assign flush = rst | clear;

  // Candidate selection: a locked packet keeps its port; otherwise round-robin
  // from the port after the last one that completed a packet.
  always_comb begin
    cand      = rq_valid_list & {NUM_INTERFACE{enable & ~fifo_full}};
    grant_vld = 1'b0;
    grant_idx = held_q;
    k         = '0;
    if (state_q == ARB_LOCKED) begin
      grant_vld = 1'b1;
    end else begin
      for (int i = 1; i <= NUM_INTERFACE; i++) begin
        k = IDX_W'((int'(rr_ptr_q) + i) % NUM_INTERFACE);
        if (!grant_vld && cand[k]) begin
          grant_vld = 1'b1;
          grant_idx = k;
        end
      end
    end
  end

  always_comb begin
    rq_ready_list = '0;
    sq_valid      = 1'b0;
    sq_last       = 1'b0;
    sq_afy        = 1'b0;
    sq_data       = '0;
    for (int i = 0; i < NUM_INTERFACE; i++) begin
      if (grant_vld && (grant_idx == IDX_W'(i))) begin
        rq_ready_list[i] = sq_ready;
        sq_valid         = rq_valid_list[i];
        sq_last          = rq_last_list[i];
        sq_afy           = rq_afy_list[i];
        sq_data          = rq_data_list[i*BW_QDATA +: BW_QDATA];
      end
    end
  end

  // Response routing; with nothing outstanding, beats are drained and flagged
  always_comb begin
    ry_valid_list = '0;
    ry_last_list  = '0;
    ry_data_list  = '0;
    sy_ready      = 1'b0;
    if (fifo_empty) begin
      sy_ready = sy_valid;
    end else begin
      for (int i = 0; i < NUM_INTERFACE; i++) begin
        if (fifo_head == IDX_W'(i)) begin
          ry_valid_list[i]                     = sy_valid;
          ry_last_list[i]                      = sy_last;
          ry_data_list[i*BW_YDATA +: BW_YDATA] = sy_data;
          sy_ready                             = ry_ready_list[i];
        end
      end
    end
  end

  assign sq_hs     = sq_valid & sq_ready;
  assign sy_hs     = sy_valid & sy_ready;
  assign fifo_push = sq_hs & (state_q == ARB_IDLE) & sq_afy;
  assign fifo_pop  = sy_hs & sy_last & ~fifo_empty;

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    rr_ptr_d = rr_ptr_q;
    orphan_d = orphan_q | (sy_valid & fifo_empty);
    if (sq_hs) begin
      if (sq_last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = grant_idx;
      end else if (state_q == ARB_IDLE) begin
        state_d = ARB_LOCKED;
        held_d  = grant_idx;
      end
    end
  end

  // Pointer resets to the last port so port 0 is first in line
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q  <= ARB_IDLE;
      held_q   <= '0;
      rr_ptr_q <= IDX_W'(NUM_INTERFACE - 1);
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      rr_ptr_q <= rr_ptr_d;
      orphan_q <= orphan_d;
    end
  end

  ervp_cache_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .W     (IDX_W)
  ) u_order_fifo (
    .clk   (clk),
    .rst   (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (grant_idx),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign busy         = (state_q == ARB_LOCKED) | ~fifo_empty;
  assign orphan_error = orphan_q;

endmodule

// File: tb/tb_ervp_cache_backend_arb.sv
// Scoreboard bench for ervp_cache_backend_arb with four ports and a 4-deep order FIFO.
module tb_ervp_cache_backend_arb;

  localparam int N  = 4;
  localparam int QW = 64;
  localparam int YW = 32;
  localparam int D  = 4;

  logic            clk = 1'b0;
  logic            rst, clear, enable, busy;
  logic [N-1:0]    rq_valid_list, rq_last_list, rq_afy_list, rq_ready_list;
  logic [QW*N-1:0] rq_data_list;
  logic [N-1:0]    ry_valid_list, ry_last_list, ry_ready_list;
  logic [YW*N-1:0] ry_data_list;
  logic            sq_valid, sq_last, sq_afy, sq_ready;
  logic [QW-1:0]   sq_data;
  logic            sy_valid, sy_last, sy_ready, orphan_error;
  logic [YW-1:0]   sy_data;

  always #5 clk = ~clk;

  ervp_cache_backend_arb #(
    .NUM_INTERFACE (N),
    .BW_QDATA      (QW),
    .BW_YDATA      (YW),
    .ORDER_DEPTH   (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .enable        (enable),
    .busy          (busy),
    .rq_valid_list (rq_valid_list),
    .rq_last_list  (rq_last_list),
    .rq_afy_list   (rq_afy_list),
    .rq_data_list  (rq_data_list),
    .rq_ready_list (rq_ready_list),
    .ry_valid_list (ry_valid_list),
    .ry_last_list  (ry_last_list),
    .ry_data_list  (ry_data_list),
    .ry_ready_list (ry_ready_list),
    .sq_valid      (sq_valid),
    .sq_last       (sq_last),
    .sq_afy        (sq_afy),
    .sq_data       (sq_data),
    .sq_ready      (sq_ready),
    .sy_valid      (sy_valid),
    .sy_last       (sy_last),
    .sy_data       (sy_data),
    .sy_ready      (sy_ready),
    .orphan_error  (orphan_error)
  );

  typedef struct { int port; logic [QW-1:0] data; logic last; logic afy; } req_t;
  typedef struct { logic [YW-1:0] data; logic last; } rsp_t;
  typedef struct { int port; logic [YW-1:0] data; logic last; } ry_t;

  req_t src_q[$];
  req_t exp_sq[$];
  rsp_t mem_q[$];
  ry_t  exp_ry[$];

  logic         rst_nx, clear_nx, en_nx, sqr_nx;
  logic [N-1:0] ryr_nx;
  logic [N-1:0] hs_rq;
  logic         hs_sy;
  logic         sq_hs_seen;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [QW-1:0] qd(input int p, input int b);
    return {32'hC0DE_0000, 16'(p), 16'(b)};
  endfunction

  task automatic push_req(input int p, input int b, input logic last, input logic afy,
                          input bit expect_beat);
    req_t r;
    r.port = p; r.data = qd(p, b); r.last = last; r.afy = afy;
    src_q.push_back(r);
    if (expect_beat) exp_sq.push_back(r);
  endtask

  task automatic push_rsp(input logic [YW-1:0] d, input logic last, input int exp_port);
    rsp_t m;
    ry_t  e;
    m.data = d; m.last = last;
    mem_q.push_back(m);
    if (exp_port >= 0) begin
      e.port = exp_port; e.data = d; e.last = last;
      exp_ry.push_back(e);
    end
  endtask

  task automatic drive();
    rst           = rst_nx;
    clear         = clear_nx;
    enable        = en_nx;
    sq_ready      = sqr_nx;
    ry_ready_list = ryr_nx;
    rq_valid_list = '0;
    rq_last_list  = '0;
    rq_afy_list   = '0;
    rq_data_list  = '0;
    for (int p = 0; p < N; p++) begin
      for (int j = 0; j < src_q.size(); j++) begin
        if (src_q[j].port == p) begin
          rq_valid_list[p]         = 1'b1;
          rq_last_list[p]          = src_q[j].last;
          rq_afy_list[p]           = src_q[j].afy;
          rq_data_list[p*QW +: QW] = src_q[j].data;
          break;
        end
      end
    end
    if (mem_q.size() > 0) begin
      sy_valid = 1'b1;
      sy_last  = mem_q[0].last;
      sy_data  = mem_q[0].data;
    end else begin
      sy_valid = 1'b0;
      sy_last  = 1'b0;
      sy_data  = '0;
    end
  endtask

  // One clock: retire last cycle's handshakes, drive, then observe at the falling edge
  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (hs_rq[p]) begin
        for (int j = 0; j < src_q.size(); j++) begin
          if (src_q[j].port == p) begin
            src_q.delete(j);
            break;
          end
        end
      end
    end
    if (hs_sy && mem_q.size() > 0) mem_q.delete(0);
    drive();
    @(negedge clk);
    hs_rq      = rq_valid_list & rq_ready_list;
    hs_sy      = sy_valid & sy_ready;
    sq_hs_seen = sq_valid & sq_ready;
    if (sq_valid && sq_ready) begin
      if (exp_sq.size() == 0) begin
        chk("sq_unexpected_beat", 1, 0);
      end else begin
        req_t e;
        e = exp_sq.pop_front();
        chk("sq_beat", {sq_data, sq_last, sq_afy}, {e.data, e.last, e.afy});
        chk("sq_grant_port", hs_rq, N'(1) << e.port);
      end
    end
    chk("ry_onehot", ($countones(ry_valid_list) <= 1), 1);
    for (int i = 0; i < N; i++) begin
      if (ry_valid_list[i] && ry_ready_list[i]) begin
        if (exp_ry.size() == 0) begin
          chk("ry_unexpected_beat", i, -1);
        end else begin
          ry_t e;
          e = exp_ry.pop_front();
          chk("ry_beat", {8'(i), ry_data_list[i*YW +: YW], ry_last_list[i]},
                         {8'(e.port), e.data, e.last});
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((exp_sq.size() != 0 || exp_ry.size() != 0) && n < max) begin
      step();
      n++;
    end
    chk(tag, (exp_sq.size() == 0 && exp_ry.size() == 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_nx = 1'b1; clear_nx = 1'b0; en_nx = 1'b1; sqr_nx = 1'b1; ryr_nx = '1;
    hs_rq = '0; hs_sy = 1'b0; sq_hs_seen = 1'b0;
    drive();
    repeat (3) step();
    rst_nx = 1'b0;
    step();
    chk("rst_sq_valid", sq_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_orphan", orphan_error, 0);
    chk("rst_rq_ready", rq_ready_list, 0);
    chk("rst_ry_valid", ry_valid_list, 0);
    chk("rst_sy_ready", sy_ready, 0);

    // All four ports at once: one grant per cycle in port order, FIFO fills
    for (int p = 0; p < N; p++) push_req(p, 0, 1'b1, 1'b1, 1);
    for (int g = 0; g < N; g++) begin
      step();
      chk("rr_consecutive_grant", sq_hs_seen, 1);
    end
    push_req(3, 1, 1'b1, 1'b0, 1);
    step();
    chk("full_blocks_ready", rq_ready_list[3], 0);
    chk("full_busy", busy, 1);
    step();
    chk("full_blocks_sq", sq_valid, 0);
    push_rsp(32'hD000_0000, 1'b1, 0);
    step();
    chk("pop_same_cycle_no_grant", rq_ready_list[3], 0);
    chk("pop_ry_port0", ry_valid_list, 4'b0001);
    step();
    chk("grant_after_pop", rq_ready_list[3], 1);
    for (int p = 1; p < N; p++) push_rsp(32'hD000_0010 + p, 1'b1, p);
    drain("drain_responses_a", 10);
    step();
    chk("idle_busy_a", busy, 0);

    // Port 2 burst holds the grant; port 1 waits even with enable dropped mid-burst
    for (int b = 0; b < 4; b++) push_req(2, b, (b == 3), 1'b0, 1);
    step();
    chk("burst_beat0", sq_hs_seen, 1);
    push_req(1, 0, 1'b1, 1'b0, 1);
    en_nx = 1'b0;
    step();
    chk("lock_hold_b1", rq_ready_list[1], 0);
    chk("lock_ignores_enable", sq_hs_seen, 1);
    step();
    chk("lock_hold_b2", rq_ready_list[1], 0);
    en_nx = 1'b1;
    step();
    chk("lock_hold_b3", rq_ready_list[1], 0);
    step();
    chk("p1_after_last", rq_ready_list[1], 1);

    // Outstanding order 1 then 3, plus a no-reply write from port 0
    push_req(1, 0, 1'b1, 1'b1, 1);
    step();
    push_req(3, 0, 1'b1, 1'b1, 1);
    step();
    push_req(0, 5, 1'b1, 1'b0, 1);
    step();
    chk("afy_busy", busy, 1);
    push_rsp(32'hD000_0100, 1'b0, 1);
    push_rsp(32'hD000_0101, 1'b1, 1);
    push_rsp(32'hD000_0300, 1'b1, 3);
    ryr_nx = 4'b1101;
    step();
    chk("ry_backpressure_sy_ready", sy_ready, 0);
    chk("ry_head_port1", ry_valid_list, 4'b0010);
    ryr_nx = '1;
    drain("drain_responses_b", 10);
    step();
    chk("afy0_pushes_nothing", busy, 0);

    // Response with nothing outstanding
    push_rsp(32'hDEAD_0000, 1'b1, -1);
    step();
    chk("orphan_sy_ready", sy_ready, 1);
    chk("orphan_not_yet", orphan_error, 0);
    chk("orphan_no_ry", ry_valid_list, 0);
    step();
    chk("orphan_set", orphan_error, 1);
    step();
    chk("orphan_sticky", orphan_error, 1);
    clear_nx = 1'b1;
    step();
    clear_nx = 1'b0;
    step();
    chk("orphan_cleared", orphan_error, 0);

    // Reset in the middle of a locked burst from port 3
    for (int b = 0; b < 4; b++) push_req(3, b, (b == 3), 1'b0, (b < 2));
    step();
    step();
    for (int j = src_q.size() - 1; j >= 0; j--) if (src_q[j].port == 3) src_q.delete(j);
    rst_nx = 1'b1;
    sqr_nx = 1'b0;
    step();
    chk("locked_busy", busy, 1);
    rst_nx = 1'b0;
    sqr_nx = 1'b1;
    push_req(0, 7, 1'b1, 1'b0, 1);
    push_req(1, 7, 1'b1, 1'b0, 1);
    step();
    chk("rst_mid_busy", busy, 0);
    chk("rst_p0_wins", rq_ready_list, 4'b0001);
    step();
    chk("rst_then_p1", sq_hs_seen, 1);

    chk("sb_sq_empty", exp_sq.size(), 0);
    chk("sb_ry_empty", exp_ry.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
